// File: rtl/mandel_job_scheduler_pkg.sv
// Shared frame geometry, field widths and scheduler state encoding for the
// Mandelbrot job scheduler slice.
package mandel_pkg;

  localparam int X_SIZE = 640;
  localparam int Y_SIZE = 480;
  localparam int XW     = 10;
  localparam int YW     = 9;
  localparam int IW     = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  // Output pixel as carried from retire to the downstream colour-map stage.
  typedef struct packed {
    logic [XW-1:0] x;
    logic [YW-1:0] y;
    logic [IW-1:0] iter;
    logic          sof;
    logic          eol;
  } pix_t;

endpackage

// File: rtl/mandel_job_scheduler_if.sv
// Job, result and pixel buses between the scheduler (master), the iteration
// engines and the downstream packer (slave side).
interface mandel_job_scheduler_if #(
  parameter int NUM_ENGINES = 4
);
  import mandel_pkg::*;

  logic [NUM_ENGINES-1:0]    job_valid;
  logic [NUM_ENGINES-1:0]    job_ready;
  logic [XW-1:0]             job_x;
  logic [YW-1:0]             job_y;
  logic [IW-1:0]             job_max_iter;

  logic [NUM_ENGINES-1:0]    res_valid;
  logic [NUM_ENGINES-1:0]    res_ready;
  logic [NUM_ENGINES*IW-1:0] res_iter;

  logic                      pix_valid;
  logic                      pix_ready;
  logic [XW-1:0]             pix_x;
  logic [YW-1:0]             pix_y;
  logic [IW-1:0]             pix_iter;
  logic                      pix_sof;
  logic                      pix_eol;

  modport master (
    output job_valid, job_x, job_y, job_max_iter,
    output res_ready,
    output pix_valid, pix_x, pix_y, pix_iter, pix_sof, pix_eol,
    input  job_ready, res_valid, res_iter, pix_ready
  );

  modport slave (
    input  job_valid, job_x, job_y, job_max_iter,
    input  res_ready,
    input  pix_valid, pix_x, pix_y, pix_iter, pix_sof, pix_eol,
    output job_ready, res_valid, res_iter, pix_ready
  );

endinterface

// File: rtl/mandel_job_scheduler_raster_counter.sv
// Raster-order x/y counter: advances one pixel per adv, wraps x at line end and
// y at frame end; flags first pixel, last pixel of line and last pixel of frame.
module raster_counter #(
  parameter int X_SIZE = mandel_pkg::X_SIZE,
  parameter int Y_SIZE = mandel_pkg::Y_SIZE
) (
  input  logic                     aclk,
  input  logic                     areset,
  input  logic                     clr,
  input  logic                     adv,
  output logic [mandel_pkg::XW-1:0] x,
  output logic [mandel_pkg::YW-1:0] y,
  output logic                     first,
  output logic                     last_x,
  output logic                     last
);
  import mandel_pkg::*;

  assign first  = (x == '0) && (y == '0);
  assign last_x = (x == XW'(X_SIZE - 1));
  assign last   = last_x && (y == YW'(Y_SIZE - 1));

  always_ff @(posedge aclk) begin
    if (areset || clr) begin
      x <= '0;
      y <= '0;
    end else if (adv) begin
      if (last_x) begin
        x <= '0;
        y <= last ? '0 : y + YW'(1);
      end else begin
        x <= x + XW'(1);
      end
    end
  end

endmodule

// File: rtl/mandel_job_scheduler.sv
// Frame sequencer: round-robin job issue to NUM_ENGINES engines, in-order retire into a
// one-entry output register (1-cycle res->pix, stalls hold it). MANDEL_SCHED_PERF_EN adds perf counters.
module mandel_job_scheduler #(
  parameter int NUM_ENGINES = 4,
  parameter int X_SIZE      = mandel_pkg::X_SIZE,
  parameter int Y_SIZE      = mandel_pkg::Y_SIZE
) (
  input  logic                     aclk,
  input  logic                     areset,
  input  logic                     start,
  input  logic [mandel_pkg::IW-1:0] cfg_max_iter,
  output logic                     busy,
  output logic                     frame_done,
  output logic [31:0]              perf_cycles,
  output logic [31:0]              perf_stalls,
  mandel_job_scheduler_if.master   bus
);
  import mandel_pkg::*;

  localparam int PW = (NUM_ENGINES > 1) ? $clog2(NUM_ENGINES) : 1;
  localparam logic [PW-1:0] LAST_ENG = PW'(NUM_ENGINES - 1);

  state_t                 state_q, state_d;
  logic [PW-1:0]          ip_q, rp_q;
  logic [NUM_ENGINES-1:0] in_flight_q;
  logic [NUM_ENGINES-1:0] ip_onehot, rp_onehot;
  logic [IW-1:0]          max_iter_q;
  logic [IW-1:0]          res_iter_sel;
  pix_t                   pix_q;
  logic                   pix_valid_q;
  logic                   pix_fin_q;
  logic                   frame_done_q;

  logic [XW-1:0] ix, rx;
  logic [YW-1:0] iy, ry;
  logic          iss_first, iss_last_x, iss_last;
  logic          ret_first, ret_last_x, ret_last;
  logic          unused_iss_flags;

  logic start_go, issue_en, issue_fire, out_free, retire_en, retire_fire, pix_take;

  always_comb begin
    ip_onehot        = '0;
    ip_onehot[ip_q]  = 1'b1;
    rp_onehot        = '0;
    rp_onehot[rp_q]  = 1'b1;
    res_iter_sel     = '0;
    for (int k = 0; k < NUM_ENGINES; k++) begin
      if (rp_q == PW'(k)) res_iter_sel = bus.res_iter[k*IW +: IW];
    end
  end

  // Issue looks only at registered in_flight, so a slot freed this cycle re-issues next cycle.
  assign start_go    = (state_q == IDLE) && start;
  assign issue_en    = (state_q == RUN) && !in_flight_q[ip_q];
  assign issue_fire  = issue_en && bus.job_ready[ip_q];
  assign pix_take    = pix_valid_q && bus.pix_ready;
  assign out_free    = !pix_valid_q || bus.pix_ready;
  assign retire_en   = in_flight_q[rp_q] && out_free;
  assign retire_fire = retire_en && bus.res_valid[rp_q];

  assign bus.job_valid    = issue_en ? ip_onehot : '0;
  assign bus.res_ready    = retire_en ? rp_onehot : '0;
  assign bus.job_x        = ix;
  assign bus.job_y        = iy;
  assign bus.job_max_iter = max_iter_q;

  assign bus.pix_valid = pix_valid_q;
  assign bus.pix_x     = pix_q.x;
  assign bus.pix_y     = pix_q.y;
  assign bus.pix_iter  = pix_q.iter;
  assign bus.pix_sof   = pix_q.sof;
  assign bus.pix_eol   = pix_q.eol;

  assign busy       = (state_q != IDLE);
  assign frame_done = frame_done_q;

  assign unused_iss_flags = iss_first | iss_last_x;

  raster_counter #(.X_SIZE(X_SIZE), .Y_SIZE(Y_SIZE)) u_issue_cnt (
    .aclk   (aclk),
    .areset (areset),
    .clr    (start_go),
    .adv    (issue_fire),
    .x      (ix),
    .y      (iy),
    .first  (iss_first),
    .last_x (iss_last_x),
    .last   (iss_last)
  );

  raster_counter #(.X_SIZE(X_SIZE), .Y_SIZE(Y_SIZE)) u_retire_cnt (
    .aclk   (aclk),
    .areset (areset),
    .clr    (start_go),
    .adv    (retire_fire),
    .x      (rx),
    .y      (ry),
    .first  (ret_first),
    .last_x (ret_last_x),
    .last   (ret_last)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (issue_fire && iss_last) state_d = DRAIN;
      DRAIN:   if (pix_take && pix_fin_q) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q      <= IDLE;
      ip_q         <= '0;
      rp_q         <= '0;
      in_flight_q  <= '0;
      max_iter_q   <= '0;
      pix_q        <= '0;
      pix_valid_q  <= 1'b0;
      pix_fin_q    <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      frame_done_q <= (state_q == DRAIN) && pix_take && pix_fin_q;

      if (start_go) begin
        ip_q        <= '0;
        rp_q        <= '0;
        in_flight_q <= '0;
        max_iter_q  <= cfg_max_iter;
      end else begin
        if (issue_fire) ip_q <= (ip_q == LAST_ENG) ? '0 : ip_q + PW'(1);
        if (retire_fire) rp_q <= (rp_q == LAST_ENG) ? '0 : rp_q + PW'(1);
        in_flight_q <= (in_flight_q & ~(retire_fire ? rp_onehot : '0))
                     | (issue_fire ? ip_onehot : '0);
      end

      if (retire_fire) begin
        pix_valid_q <= 1'b1;
        pix_q.x     <= rx;
        pix_q.y     <= ry;
        pix_q.iter  <= res_iter_sel;
        pix_q.sof   <= ret_first;
        pix_q.eol   <= ret_last_x;
        pix_fin_q   <= ret_last;
      end else if (bus.pix_ready) begin
        pix_valid_q <= 1'b0;
      end
    end
  end

`ifdef MANDEL_SCHED_PERF_EN
  logic [31:0] perf_cycles_q, perf_stalls_q;

  // The start cycle counts as the first cycle; the frame_done cycle is the last.
  always_ff @(posedge aclk) begin
    if (areset) begin
      perf_cycles_q <= '0;
      perf_stalls_q <= '0;
    end else if (start_go) begin
      perf_cycles_q <= 32'd1;
      perf_stalls_q <= '0;
    end else begin
      if ((state_q != IDLE) || frame_done_q) perf_cycles_q <= perf_cycles_q + 32'd1;
      if (pix_valid_q && !bus.pix_ready)     perf_stalls_q <= perf_stalls_q + 32'd1;
    end
  end

  assign perf_cycles = perf_cycles_q;
  assign perf_stalls = perf_stalls_q;
`else
  assign perf_cycles = 32'd0;
  assign perf_stalls = 32'd0;
`endif

endmodule

// File: tb/tb_mandel_job_scheduler.sv
// Scoreboard bench: 4x2 frame over 2 modelled engines with configurable latency,
// downstream stalls, restart attempts while busy and mid-frame reset.
module tb_mandel_job_scheduler;
  import mandel_pkg::*;

  localparam int N    = 2;
  localparam int XS   = 4;
  localparam int YS   = 2;
  localparam int NPIX = XS * YS;

  logic          aclk = 1'b0;
  logic          areset = 1'b1;
  logic          start = 1'b0;
  logic [IW-1:0] cfg_max_iter = '0;
  logic          busy, frame_done;
  logic [31:0]   perf_cycles, perf_stalls;

  mandel_job_scheduler_if #(.NUM_ENGINES(N)) bus ();

  mandel_job_scheduler #(.NUM_ENGINES(N), .X_SIZE(XS), .Y_SIZE(YS)) dut (
    .aclk         (aclk),
    .areset       (areset),
    .start        (start),
    .cfg_max_iter (cfg_max_iter),
    .busy         (busy),
    .frame_done   (frame_done),
    .perf_cycles  (perf_cycles),
    .perf_stalls  (perf_stalls),
    .bus          (bus)
  );

  always #5 aclk = ~aclk;

  int cyc = 0;
  always @(posedge aclk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // Engine models and bench-side expectations
  bit            eng_busy [N];
  int            eng_cnt  [N];
  logic [IW-1:0] eng_val  [N];
  int            lat      [N];
  bit            fire_job [N];
  bit            fire_res [N];
  logic [IW-1:0] fire_val [N];

  pix_t sb[$];
  pix_t held, exp_pix;
  bit   held_vld;
  int   bx, by, exp_rp, acc_cnt, fd_count, fd_cyc, last_acc_cyc, start_cyc;
  int   stall_len, stall_left, viol_rr, viol_dbl, exp_max;
  bit   stall_arm;
  logic [N-1:0] rr_mask;

  initial begin
    for (int k = 0; k < N; k++) lat[k] = 1;
    forever begin
      @(negedge aclk);
      if (areset) begin
        for (int k = 0; k < N; k++) begin
          eng_busy[k] = 0; eng_cnt[k] = 0; eng_val[k] = '0;
          fire_job[k] = 0; fire_res[k] = 0;
        end
        bus.job_ready = '0;
        bus.res_valid = '0;
        bus.res_iter  = '0;
        bus.pix_ready = 1'b1;
        held_vld      = 0;
        stall_left    = 0;
        continue;
      end
      for (int k = 0; k < N; k++) if (fire_res[k]) eng_busy[k] = 0;
      for (int k = 0; k < N; k++) begin
        if (fire_job[k]) begin
          eng_busy[k] = 1; eng_cnt[k] = lat[k]; eng_val[k] = fire_val[k];
        end
        if (eng_busy[k] && eng_cnt[k] > 0) eng_cnt[k]--;
        bus.res_valid[k]           = eng_busy[k] && (eng_cnt[k] == 0);
        bus.res_iter[k*IW +: IW]   = eng_val[k];
        bus.job_ready[k]           = !eng_busy[k];
      end
      if (stall_arm && bus.pix_valid && acc_cnt >= 2) begin
        stall_left = stall_len;
        stall_arm  = 0;
      end
      bus.pix_ready = (stall_left == 0);
      if (stall_left > 0) stall_left--;
      #1;
      rr_mask = '0;
      rr_mask[exp_rp] = 1'b1;
      if ((bus.res_ready & ~rr_mask) != '0) viol_rr++;
      if ($countones(bus.job_valid) > 1) viol_dbl++;
      for (int k = 0; k < N; k++) begin
        if (bus.job_valid[k] && eng_busy[k]) viol_dbl++;
        fire_res[k] = bus.res_valid[k] && bus.res_ready[k];
        fire_job[k] = bus.job_valid[k] && bus.job_ready[k];
        if (fire_res[k] && k != exp_rp) viol_rr++;
      end
      if (fire_res[exp_rp]) exp_rp = (exp_rp + 1) % N;
      for (int k = 0; k < N; k++) begin
        if (fire_job[k]) begin
          check("job_x", bus.job_x, bx);
          check("job_y", bus.job_y, by);
          check("job_max_iter", bus.job_max_iter, exp_max);
          fire_val[k] = IW'(int'(bus.job_x) + 4 * int'(bus.job_y));
          exp_pix.x    = XW'(bx);
          exp_pix.y    = YW'(by);
          exp_pix.iter = IW'(bx + XS * by);
          exp_pix.sof  = (bx == 0) && (by == 0);
          exp_pix.eol  = (bx == XS - 1);
          sb.push_back(exp_pix);
          if (bx == XS - 1) begin bx = 0; by = (by + 1) % YS; end
          else bx++;
        end
      end
      if (bus.pix_valid) begin
        if (held_vld)
          check("pix_hold", {bus.pix_x, bus.pix_y, bus.pix_iter, bus.pix_sof, bus.pix_eol}, held);
        if (bus.pix_ready) begin
          if (sb.size() == 0) begin
            check("pix_unexpected", acc_cnt, NPIX + 100);
          end else begin
            exp_pix = sb.pop_front();
            check("pix_xy", {bus.pix_x, bus.pix_y}, {exp_pix.x, exp_pix.y});
            check("pix_iter", bus.pix_iter, exp_pix.iter);
            check("pix_sof_eol", {bus.pix_sof, bus.pix_eol}, {exp_pix.sof, exp_pix.eol});
          end
          acc_cnt++;
          if (acc_cnt == NPIX) last_acc_cyc = cyc;
          held_vld = 0;
        end else begin
          held_vld = 1;
          held = {bus.pix_x, bus.pix_y, bus.pix_iter, bus.pix_sof, bus.pix_eol};
        end
      end
      if (frame_done) begin fd_count++; fd_cyc = cyc; end
    end
  end

  task automatic check_idle_outputs(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_frame_done"}, frame_done, 0);
    check({tag, "_job_valid"}, bus.job_valid, 0);
    check({tag, "_res_ready"}, bus.res_ready, 0);
    check({tag, "_pix_valid"}, bus.pix_valid, 0);
    check({tag, "_pix_fields"}, {bus.pix_x, bus.pix_y, bus.pix_iter, bus.pix_sof, bus.pix_eol}, 0);
    check({tag, "_job_xy"}, {bus.job_x, bus.job_y}, 0);
  endtask

  task automatic begin_frame(input int l0, input int l1, input int maxi, input int slen);
    @(negedge aclk); #2;
    lat[0] = l0; lat[1] = l1;
    bx = 0; by = 0; exp_rp = 0; acc_cnt = 0; fd_count = 0; fd_cyc = 0; last_acc_cyc = 0;
    stall_len = slen; stall_left = 0; stall_arm = (slen > 0);
    viol_rr = 0; viol_dbl = 0; held_vld = 0;
    sb.delete();
    exp_max = maxi;
    cfg_max_iter = IW'(maxi);
    start = 1'b1;
    start_cyc = cyc;
    @(negedge aclk); #2;
    start = 1'b0;
    check("start_busy", busy, 1);
    check("start_first_job_valid", bus.job_valid, 1);
  endtask

  task automatic end_frame(input int slen);
    int t;
    t = 0;
    while (fd_count == 0 && t < 500) begin @(negedge aclk); #2; t++; end
    check("frame_done_seen", fd_count, 1);
    @(negedge aclk); #2;
    check("frame_done_pulses", fd_count, 1);
    check("frame_done_after_last", fd_cyc - last_acc_cyc, 1);
    check("pix_count", acc_cnt, NPIX);
    check("sb_empty", sb.size(), 0);
    check("rr_order", viol_rr, 0);
    check("single_job_per_engine", viol_dbl, 0);
    check("stall_applied", stall_arm, 0);
    check("busy_after_frame", busy, 0);
`ifdef MANDEL_SCHED_PERF_EN
    check("perf_cycles", perf_cycles, fd_cyc - start_cyc + 1);
    check("perf_stalls", perf_stalls, slen);
`else
    check("perf_cycles_off", perf_cycles, 0);
    check("perf_stalls_off", perf_stalls, 0);
`endif
  endtask

  task automatic run_frame(input int l0, input int l1, input int maxi, input int slen, input bit cfgchg);
    int t;
    begin_frame(l0, l1, maxi, slen);
    if (cfgchg) begin
      t = 0;
      while (acc_cnt < 3 && t < 200) begin @(negedge aclk); #2; t++; end
      cfg_max_iter = 8'd7;
      start = 1'b1;
      @(negedge aclk); #2;
      start = 1'b0;
      check("restart_while_busy", busy, 1);
    end
    end_frame(slen);
  endtask

  initial begin
    int t;
    areset = 1'b1;
    repeat (3) @(posedge aclk);
    @(negedge aclk); #2;
    check_idle_outputs("reset");
    areset = 1'b0;

    run_frame(3, 3, 50, 0, 0);
    run_frame(1, 10, 50, 0, 0);
    run_frame(2, 2, 50, 5, 0);
    run_frame(3, 3, 100, 0, 1);
    run_frame(0, 0, 0, 0, 0);

    begin_frame(2, 2, 50, 0);
    t = 0;
    while (acc_cnt < 3 && t < 200) begin @(negedge aclk); #2; t++; end
    check("pre_reset_pixels", acc_cnt >= 3, 1);
    areset = 1'b1;
    @(negedge aclk); #2;
    check_idle_outputs("midframe_reset");
    areset = 1'b0;
    run_frame(2, 2, 50, 0, 0);

    run_frame(1, 1, 50, 4, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

endmodule

// File: doc/mandel_job_scheduler.md
Name: mandel_job_scheduler

Overview:
- Sequences one Mandelbrot frame across NUM_ENGINES parallel iteration engines.
- Generates pixel coordinates in raster order and dispatches them to engines in strict round-robin order.
- Retires engine results in the same round-robin order, so the output pixel stream is always raster-ordered.
- Sits between the AXI-Lite register file (start/max_iter) and the colour-map/packer stage.

Parameters:
- NUM_ENGINES, 4, number of iteration engines (2..8).
- X_SIZE, 640, pixels per line.
- Y_SIZE, 480, lines per frame.
- XW, 10, x coordinate width.
- YW, 9, y coordinate width.
- IW, 8, iteration count width.

Ports:
- aclk  in  1  sole clock
- areset  in  1  synchronous, active-high reset
- start  in  1  pulse; begins a frame when idle
- cfg_max_iter  in  IW  iteration limit, latched at start
- busy  out  1  frame in progress
- frame_done  out  1  one-cycle pulse after last pixel retires
- job_valid  out  NUM_ENGINES  one-hot job offer to engine k
- job_ready  in  NUM_ENGINES  engine k accepts job
- job_x  out  XW  shared job x coordinate
- job_y  out  YW  shared job y coordinate
- job_max_iter  out  IW  latched limit, shared
- res_valid  in  NUM_ENGINES  engine k result available
- res_ready  out  NUM_ENGINES  one-hot result accept
- res_iter  in  NUM_ENGINES*IW  packed iteration counts; engine k at [k*IW +: IW]
- pix_valid  out  1  output pixel valid
- pix_ready  in  1  downstream ready
- pix_x  out  XW  output pixel x
- pix_y  out  YW  output pixel y
- pix_iter  out  IW  output iteration count
- pix_sof  out  1  first pixel of frame
- pix_eol  out  1  last pixel of line

Behaviour:
- Reset (synchronous, areset=1): state IDLE.
  - All counters and pointers = 0; in_flight = 0.
  - busy = 0, frame_done = 0, job_valid = 0, res_ready = 0, pix_valid = 0.
  - pix_x, pix_y, pix_iter, pix_sof, pix_eol = 0.
  - Reset mid-frame abandons all jobs; engines are reset by the same reset.
- States:
  - IDLE: start=1 latches cfg_max_iter, clears counters and pointers, then moves to RUN; busy=1 from the next cycle.
  - RUN: issue and retire proceed concurrently. When the last job has issued, move to DRAIN.
  - DRAIN: retire only. When the last pixel is accepted downstream, frame_done=1 for one cycle, then return to IDLE.
- Issue path:
  - Issue pointer ip (0..NUM_ENGINES-1); issue raster counters ix, iy.
  - job_valid[ip]=1 when in RUN and in_flight[ip]=0.
  - job_x/job_y = ix/iy, presented combinationally from registers.
  - On job_valid[ip] & job_ready[ip]: set in_flight[ip], advance ip with wrap to 0, advance ix.
  - At ix=X_SIZE-1, ix wraps to 0 and iy increments.
  - The job at ix=X_SIZE-1, iy=Y_SIZE-1 is the last; RUN then goes to DRAIN.
  - At most one issue per cycle.
- Retire path:
  - Retire pointer rp; retire raster counters rx, ry; one-entry output register.
  - res_ready[rp]=1 when in_flight[rp]=1 and the output register is empty or being drained this cycle (pix_ready=1).
  - On res_valid[rp] & res_ready[rp]: load pix_iter from res_iter slice rp, pix_x=rx, pix_y=ry.
  - Same handshake: pix_sof=(rx==0 && ry==0), pix_eol=(rx==X_SIZE-1), set pix_valid, clear in_flight[rp], advance rp and rx/ry with the same wrap rules.
  - Results from engines other than rp are ignored (res_ready stays 0) until their turn.
- Output hold:
  - pix_valid with pix_ready=0 holds every pix_* field stable.
  - Full throughput is one pixel per cycle when the engines keep up.
- Simultaneous events:
  - Issue to engine k and retire from engine k in the same cycle is legal only if retire clears in_flight first. Issue requires in_flight=0 as registered, so a same-cycle re-issue waits one cycle.
  - start while busy is ignored. cfg_max_iter changes while busy are ignored.
- Iteration limit:
  - cfg_max_iter=0 is passed through unchanged; engines return iter=0.
  - The scheduler does not interpret iteration counts.
- Latency:
  - start to first job_valid: 1 cycle.
  - res handshake to pix_valid: 1 cycle.

Optional Feature:
- Macro MANDEL_SCHED_PERF_EN.
- Defined:
  - Extra outputs perf_cycles[31:0] counts cycles from start to frame_done inclusive.
  - perf_stalls[31:0] counts cycles with pix_valid=1 and pix_ready=0.
  - Both clear at start, hold after frame_done, and reset to 0.
- Undefined: both outputs are driven constant 0; no counters are synthesised.

Decomposition:
- Package mandel_pkg:
  - Constants X_SIZE, Y_SIZE, XW, YW, IW.
  - State encoding IDLE/RUN/DRAIN.
- Sub-module raster_counter (x/y wrap counter with advance input, first/last flags), instantiated twice: issue and retire.

Test Plan:
- X_SIZE=4, Y_SIZE=2, NUM_ENGINES=2, engines always ready, fixed 3-cycle latency, iter=x+4y -> 8 pixels with pix_iter 0..7 in order. pix_sof only on (0,0); pix_eol on x=3; frame_done 1 cycle after the 8th accept.
- Engine 1 latency 10, engine 0 latency 1 -> output still raster ordered. Engine 0 never holds more than one job; res_ready[0] stays 0 while rp=1.
- pix_ready low 5 cycles mid-frame -> pix_* stable throughout; no result lost; total 8 pixels.
- cfg_max_iter=100 at start, changed to 7 mid-frame, second start pulse while busy -> job_max_iter=100 for the whole frame; no restart.
- areset asserted after 3 pixels retired -> next cycle all outputs 0 and IDLE. A following start produces a full frame beginning at (0,0) with pix_sof=1.
- MANDEL_SCHED_PERF_EN defined, pix_ready held low 4 cycles -> perf_stalls=4; perf_cycles equals the measured start-to-frame_done span.
